// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: IF/ID fields in, registered ID/EX fields and stall out.
// ID_EX_PERF_CNT_EN adds the perf_bubbles/perf_flushes counters to the bundle.
interface id_ex_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
);
    logic              if_id_valid;
    logic [REG_AW-1:0] if_id_rs1;
    logic [REG_AW-1:0] if_id_rs2;
    logic [REG_AW-1:0] if_id_rd;
    logic [XLEN-1:0]   if_id_rdata1;
    logic [XLEN-1:0]   if_id_rdata2;
    logic [XLEN-1:0]   if_id_imm;
    logic [7:0]        if_id_ctrl;
    logic              flush;

    logic              id_ex_valid;
    logic [REG_AW-1:0] id_ex_rs1;
    logic [REG_AW-1:0] id_ex_rs2;
    logic [REG_AW-1:0] id_ex_rd;
    logic [XLEN-1:0]   id_ex_rdata1;
    logic [XLEN-1:0]   id_ex_rdata2;
    logic [XLEN-1:0]   id_ex_imm;
    logic [7:0]        id_ex_ctrl;
    logic              stall;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]       perf_bubbles;
    logic [31:0]       perf_flushes;

    modport master (
        output if_id_valid, if_id_rs1, if_id_rs2, if_id_rd,
               if_id_rdata1, if_id_rdata2, if_id_imm, if_id_ctrl, flush,
        input  id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_ctrl, stall,
               perf_bubbles, perf_flushes
    );
    modport slave (
        input  if_id_valid, if_id_rs1, if_id_rs2, if_id_rd,
               if_id_rdata1, if_id_rdata2, if_id_imm, if_id_ctrl, flush,
        output id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_ctrl, stall,
               perf_bubbles, perf_flushes
    );
`else
    modport master (
        output if_id_valid, if_id_rs1, if_id_rs2, if_id_rd,
               if_id_rdata1, if_id_rdata2, if_id_imm, if_id_ctrl, flush,
        input  id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_ctrl, stall
    );
    modport slave (
        input  if_id_valid, if_id_rs1, if_id_rs2, if_id_rd,
               if_id_rdata1, if_id_rdata2, if_id_imm, if_id_ctrl, flush,
        output id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_ctrl, stall
    );
`endif
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and multi-cycle bubble insertion.
// Define ID_EX_PERF_CNT_EN to add stall/flush performance counters.
module id_ex_stage #(
    parameter int XLEN         = 64,
    parameter int REG_AW       = 5,
    parameter int STALL_CYCLES = 1
) (
    input logic   clk,
    input logic   reset,
    id_ex_if.slave bus
);
    localparam int CNT_W = $clog2(STALL_CYCLES + 1);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              valid_reg;
    logic [REG_AW-1:0] rs1_reg;
    logic [REG_AW-1:0] rs2_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [XLEN-1:0]   rdata1_reg;
    logic [XLEN-1:0]   rdata2_reg;
    logic [XLEN-1:0]   imm_reg;
    logic [7:0]        ctrl_reg;

    logic rd_match;
    logic hazard;
    logic stall;
    logic load_en;

    // Only a real load in ID/EX writing a non-x0 register can create a hazard.
    assign rd_match = (rd_reg == bus.if_id_rs1) || (rd_reg == bus.if_id_rs2);
    assign hazard   = (state_reg == RUN) && valid_reg && ctrl_reg[6] &&
                      (rd_reg != '0) && bus.if_id_valid && rd_match;
    assign stall    = !bus.flush && ((state_reg == BUBBLE) || hazard);
    assign load_en  = bus.if_id_valid && !stall && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= RUN;
            cnt_reg    <= '0;
            valid_reg  <= 1'b0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            rd_reg     <= '0;
            rdata1_reg <= '0;
            rdata2_reg <= '0;
            imm_reg    <= '0;
            ctrl_reg   <= '0;
        end else begin
            // Every slot is either the IF/ID instruction or an all-zero bubble.
            valid_reg  <= load_en;
            rs1_reg    <= load_en ? bus.if_id_rs1    : '0;
            rs2_reg    <= load_en ? bus.if_id_rs2    : '0;
            rd_reg     <= load_en ? bus.if_id_rd     : '0;
            rdata1_reg <= load_en ? bus.if_id_rdata1 : '0;
            rdata2_reg <= load_en ? bus.if_id_rdata2 : '0;
            imm_reg    <= load_en ? bus.if_id_imm    : '0;
            ctrl_reg   <= load_en ? bus.if_id_ctrl   : '0;
            if (bus.flush) begin
                state_reg <= RUN;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    RUN: begin
                        if (hazard && (STALL_CYCLES > 1)) begin
                            state_reg <= BUBBLE;
                            cnt_reg   <= CNT_W'(STALL_CYCLES - 1);
                        end
                    end
                    BUBBLE: begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg <= RUN;
                        end
                    end
                    default: begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.id_ex_valid  = valid_reg;
    assign bus.id_ex_rs1    = rs1_reg;
    assign bus.id_ex_rs2    = rs2_reg;
    assign bus.id_ex_rd     = rd_reg;
    assign bus.id_ex_rdata1 = rdata1_reg;
    assign bus.id_ex_rdata2 = rdata2_reg;
    assign bus.id_ex_imm    = imm_reg;
    assign bus.id_ex_ctrl   = ctrl_reg;

`ifdef ID_EX_PERF_CNT_EN
    logic [1:0] perf_inc;
    assign perf_inc = {bus.flush, stall};

    // Index 0 counts stall cycles, index 1 counts flush cycles; both wrap.
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (perf_inc[gi]) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign bus.perf_bubbles = g_perf[0].cnt_reg;
    assign bus.perf_flushes = g_perf[1].cnt_reg;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (STALL_CYCLES=1 and 2) share stimulus and a scoreboard.
// Perf counter checks are compiled in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;
    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
        logic [7:0]  ctrl;
    } slot_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus0 ();
    id_ex_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus1 ();

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .STALL_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .STALL_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    st_cnt [2];
    slot_t m_slot [2];
    int    m_left [2];
    logic [31:0] m_pb [2];
    logic [31:0] m_pf [2];
    slot_t sb_q0 [$];
    slot_t sb_q1 [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic slot_t mk(input logic v, input int r1, input int r2, input int rd,
                                 input logic [7:0] c);
        slot_t s;
        s.valid = v;
        s.rs1   = 5'(r1);
        s.rs2   = 5'(r2);
        s.rd    = 5'(rd);
        s.d1    = {$urandom, $urandom};
        s.d2    = {$urandom, $urandom};
        s.imm   = {$urandom, $urandom};
        s.ctrl  = c;
        return s;
    endfunction

    function automatic slot_t rnd_instr();
        logic [7:0] c;
        c    = 8'($urandom);
        c[6] = 1'($urandom_range(0, 1));
        return mk($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), c);
    endfunction

    function automatic slot_t obs(input int k);
        if (k == 0)
            return {bus0.id_ex_valid, bus0.id_ex_rs1, bus0.id_ex_rs2, bus0.id_ex_rd,
                    bus0.id_ex_rdata1, bus0.id_ex_rdata2, bus0.id_ex_imm, bus0.id_ex_ctrl};
        return {bus1.id_ex_valid, bus1.id_ex_rs1, bus1.id_ex_rs2, bus1.id_ex_rd,
                bus1.id_ex_rdata1, bus1.id_ex_rdata2, bus1.id_ex_imm, bus1.id_ex_ctrl};
    endfunction

    // One clock: drive, check stall, predict next ID/EX slot, then compare after the edge.
    task automatic step(input slot_t i, input logic fl, input logic rs, input bit chk_stall);
        slot_t nx;
        slot_t want;
        logic  hz, st_exp, st_obs;
        int    sc;
        reset = rs;
        bus0.if_id_valid = i.valid; bus1.if_id_valid = i.valid;
        bus0.if_id_rs1 = i.rs1;     bus1.if_id_rs1 = i.rs1;
        bus0.if_id_rs2 = i.rs2;     bus1.if_id_rs2 = i.rs2;
        bus0.if_id_rd = i.rd;       bus1.if_id_rd = i.rd;
        bus0.if_id_rdata1 = i.d1;   bus1.if_id_rdata1 = i.d1;
        bus0.if_id_rdata2 = i.d2;   bus1.if_id_rdata2 = i.d2;
        bus0.if_id_imm = i.imm;     bus1.if_id_imm = i.imm;
        bus0.if_id_ctrl = i.ctrl;   bus1.if_id_ctrl = i.ctrl;
        bus0.flush = fl;            bus1.flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            sc     = (k == 0) ? 1 : 2;
            st_obs = (k == 0) ? bus0.stall : bus1.stall;
            hz = m_slot[k].valid && m_slot[k].ctrl[6] && (m_slot[k].rd != 5'd0) && i.valid &&
                 ((m_slot[k].rd == i.rs1) || (m_slot[k].rd == i.rs2));
            st_exp = !fl && ((m_left[k] > 0) || hz);
            if (chk_stall) check($sformatf("stall%0d", k), 256'(st_obs), 256'(st_exp));
            if (st_obs === 1'b1) st_cnt[k]++;
            if (rs || fl) begin
                nx = '0;
                m_left[k] = 0;
            end else if (st_exp) begin
                nx = '0;
                m_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : sc - 1;
            end else begin
                nx = i.valid ? i : '0;
            end
            m_slot[k] = nx;
            if (rs) begin
                m_pb[k] = '0;
                m_pf[k] = '0;
            end else begin
                m_pb[k] = m_pb[k] + 32'(st_exp);
                m_pf[k] = m_pf[k] + 32'(fl);
            end
            if (k == 0) sb_q0.push_back(nx);
            else        sb_q1.push_back(nx);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            want = (k == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
            check($sformatf("slot%0d", k), 256'(obs(k)), 256'(want));
        end
`ifdef ID_EX_PERF_CNT_EN
        check("perf_b0", 256'(bus0.perf_bubbles), 256'(m_pb[0]));
        check("perf_f0", 256'(bus0.perf_flushes), 256'(m_pf[0]));
        check("perf_b1", 256'(bus1.perf_bubbles), 256'(m_pb[1]));
        check("perf_f1", 256'(bus1.perf_flushes), 256'(m_pf[1]));
`endif
        $display("[TB] cyc %0d rst=%0b flush=%0b v=%0b rs1=%0d rs2=%0d rd=%0d ctrl=%02h ex_v=%0b/%0b",
                 cyc, rs, fl, i.valid, i.rs1, i.rs2, i.rd, i.ctrl,
                 bus0.id_ex_valid, bus1.id_ex_valid);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        slot_t idle, ld, use_i;
        for (int k = 0; k < 2; k++) begin
            m_slot[k] = '0; m_left[k] = 0; m_pb[k] = '0; m_pf[k] = '0; st_cnt[k] = 0;
        end
        idle = mk(0, 0, 0, 0, 8'h00);

        // Reset held two clocks with random inputs
        step(rnd_instr(), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        step(rnd_instr(), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        check("rst_valid", 256'(bus0.id_ex_valid), 256'(0));
        check("rst_ctrl", 256'(bus1.id_ex_ctrl), 256'(0));

        // Pass-through
        step(mk(1, 1, 2, 3, 8'h80), 1'b0, 1'b0, 1'b1);
        check("pt_rs1", 256'(bus0.id_ex_rs1), 256'(1));
        check("pt_rs2", 256'(bus0.id_ex_rs2), 256'(2));
        check("pt_rd", 256'(bus0.id_ex_rd), 256'(3));
        check("pt_ctrl", 256'(bus0.id_ex_ctrl), 256'(8'h80));

        // Load-use on rs2, instruction held while stalled
        step(mk(1, 1, 2, 5, 8'hD8), 1'b0, 1'b0, 1'b1);
        use_i = mk(1, 6, 5, 8, 8'h80);
        st_cnt[0] = 0; st_cnt[1] = 0;
        for (int n = 0; n < 3; n++) step(use_i, 1'b0, 1'b0, 1'b1);
        check("lu_stalls0", 256'(st_cnt[0]), 256'(1));
        check("lu_stalls1", 256'(st_cnt[1]), 256'(2));
        check("lu_rs2_0", 256'(bus0.id_ex_rs2), 256'(5));
        check("lu_rs2_1", 256'(bus1.id_ex_rs2), 256'(5));

        // Load into x0 never stalls
        step(mk(1, 1, 2, 0, 8'hD8), 1'b0, 1'b0, 1'b1);
        st_cnt[0] = 0; st_cnt[1] = 0;
        step(mk(1, 0, 4, 9, 8'h80), 1'b0, 1'b0, 1'b1);
        check("x0_stalls", 256'(st_cnt[0] + st_cnt[1]), 256'(0));
        check("x0_rs2", 256'(bus1.id_ex_rs2), 256'(4));

        // Flush during a two-cycle stall
        step(mk(1, 1, 2, 7, 8'hD8), 1'b0, 1'b0, 1'b1);
        use_i = mk(1, 7, 3, 10, 8'h80);
        step(use_i, 1'b0, 1'b0, 1'b1);
        step(use_i, 1'b1, 1'b0, 1'b1);
        check("fl_valid", 256'(bus1.id_ex_valid), 256'(0));
        st_cnt[1] = 0;
        step(use_i, 1'b0, 1'b0, 1'b1);
        check("fl_nostall", 256'(st_cnt[1]), 256'(0));
        check("fl_rs1", 256'(bus1.id_ex_rs1), 256'(7));

        // Reset in the middle of BUBBLE
        step(mk(1, 1, 2, 11, 8'hD8), 1'b0, 1'b0, 1'b1);
        use_i = mk(1, 11, 3, 12, 8'h80);
        step(use_i, 1'b0, 1'b0, 1'b1);
        step(use_i, 1'b0, 1'b1, 1'b1);
        check("rb_valid", 256'(bus1.id_ex_valid), 256'(0));
        st_cnt[1] = 0;
        step(idle, 1'b0, 1'b0, 1'b1);
        check("rb_nostall", 256'(st_cnt[1]), 256'(0));

        // Three hazards plus two flushes
        step(idle, 1'b0, 1'b1, 1'b1);
        for (int h = 0; h < 3; h++) begin
            ld    = mk(1, 1, 2, 12 + h, 8'hD8);
            use_i = mk(1, 3, 12 + h, 20, 8'h80);
            step(ld, 1'b0, 1'b0, 1'b1);
            for (int n = 0; n < 3; n++) step(use_i, 1'b0, 1'b0, 1'b1);
        end
        step(idle, 1'b1, 1'b0, 1'b1);
        step(idle, 1'b1, 1'b0, 1'b1);
        step(idle, 1'b0, 1'b0, 1'b1);
`ifdef ID_EX_PERF_CNT_EN
        check("pc_bub0", 256'(bus0.perf_bubbles), 256'(3));
        check("pc_bub1", 256'(bus1.perf_bubbles), 256'(6));
        check("pc_fl0", 256'(bus0.perf_flushes), 256'(2));
        check("pc_fl1", 256'(bus1.perf_flushes), 256'(2));
        step(idle, 1'b0, 1'b1, 1'b1);
        check("pc_rst_b", 256'(bus1.perf_bubbles), 256'(0));
        check("pc_rst_f", 256'(bus1.perf_flushes), 256'(0));
`endif

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 300; n++) begin
            step(rnd_instr(), 1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 99) < 2), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
